boid_mem_sched: RTL

- Memory-side sequencer that feeds the boid accelerator datapath and takes its results back. It owns the boid state RAM: NUM_BOIDS entries, each holding x, y, vx and vy as 32-bit fix16 words.
- Per frame, it walks each target boid i in turn:
  - pulses the accumulator clear,
  - presents boid i with r_en_tot,
  - streams every other boid with r_en_itr,
  - writes the accelerator's x/y/vx/vy outputs back into entry i.
- Sits between the host/init logic, the VGA draw path (second read port) and the accelerator datapath.

---
 rtl/boid_mem_sched.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/boid_mem_sched.sv
// Boid state RAM plus the per-frame sequencer that streams targets and neighbours to the accelerator.
// Optional frame-cycle counter is built only when BOID_SCHED_PERF_EN is defined.
module boid_mem_sched #(
    parameter int NUM_BOIDS = 32,
    parameter int ADDR_W    = $clog2(NUM_BOIDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_x,
    input  logic [31:0]       host_y,
    input  logic [31:0]       host_vx,
    input  logic [31:0]       host_vy,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_x,
    output logic [31:0]       disp_y,
    output logic              acc_clr,
    output logic              r_en_tot,
    output logic              r_en_itr,
    output logic [31:0]       x_in_xcel,
    output logic [31:0]       y_in_xcel,
    output logic [31:0]       vx_in_xcel,
    output logic [31:0]       vy_in_xcel,
    input  logic [31:0]       x_out_xcel,
    input  logic [31:0]       y_out_xcel,
    input  logic [31:0]       vx_out_xcel,
    input  logic [31:0]       vy_out_xcel,
    output logic [31:0]       frame_cycles
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_TGT   = 3'd2;
    localparam logic [2:0] ST_SCAN  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_WB    = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BOIDS - 1);

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] i_reg, i_next;
    logic [ADDR_W-1:0] j_reg, j_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              itr_vld_reg;
    logic [ADDR_W-1:0] itr_idx_reg;

    logic              idle_open;
    logic              start_accept;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata [4];

    // The done cycle is still busy, so neither start nor host writes are taken there.
    assign idle_open    = (state_reg == ST_IDLE) && !busy_reg;
    assign start_accept = idle_open && start;

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        if (done_reg) begin
            busy_next = 1'b0;
        end
        case (state_reg)
            ST_IDLE: begin
                if (start_accept) begin
                    state_next = ST_CLR;
                    i_next     = '0;
                    j_next     = '0;
                    busy_next  = 1'b1;
                end
            end
            ST_CLR: begin
                state_next = ST_TGT;
            end
            ST_TGT: begin
                j_next     = '0;
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                j_next = j_reg + ADDR_W'(1);
                if (j_reg == LAST_IDX) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_WB;
            end
            ST_WB: begin
                if (i_reg == LAST_IDX) begin
                    done_next  = 1'b1;
                    i_next     = '0;
                    state_next = ST_IDLE;
                end else begin
                    i_next     = i_reg + ADDR_W'(1);
                    state_next = ST_CLR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            itr_vld_reg <= 1'b0;
            itr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            i_reg       <= i_next;
            j_reg       <= j_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            itr_vld_reg <= (state_reg == ST_SCAN);
            itr_idx_reg <= j_reg;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign acc_clr  = (state_reg == ST_CLR);
    assign r_en_tot = (state_reg == ST_TGT);
    // Self slot is read like any other neighbour but never accumulated.
    assign r_en_itr = itr_vld_reg && (itr_idx_reg != i_reg);

    // DRAIN and WB point port A at the target so WB presents boid i on the read bus.
    always_comb begin
        case (state_reg)
            ST_IDLE: a_addr = host_addr;
            ST_TGT:  a_addr = '0;
            ST_SCAN: a_addr = j_reg;
            default: a_addr = i_reg;
        endcase
    end

    assign a_we = (idle_open && host_we) || (state_reg == ST_WB);

    always_comb begin
        if (state_reg == ST_WB) begin
            a_wdata[0] = x_out_xcel;
            a_wdata[1] = y_out_xcel;
            a_wdata[2] = vx_out_xcel;
            a_wdata[3] = vy_out_xcel;
        end else begin
            a_wdata[0] = host_x;
            a_wdata[1] = host_y;
            a_wdata[2] = host_vx;
            a_wdata[3] = host_vy;
        end
    end

    // One dual-port RAM per field; port B reads old data on a same-address port-A write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_field
            logic [31:0] mem [NUM_BOIDS];
            logic [31:0] a_rd_reg;
            logic [31:0] b_rd_reg;

            always_ff @(posedge clk) begin
                if (a_we) begin
                    mem[a_addr] <= a_wdata[gi];
                end
                a_rd_reg <= mem[a_addr];
            end

            always_ff @(posedge clk) begin
                b_rd_reg <= mem[disp_addr];
            end
        end
    endgenerate

    assign x_in_xcel  = g_field[0].a_rd_reg;
    assign y_in_xcel  = g_field[1].a_rd_reg;
    assign vx_in_xcel = g_field[2].a_rd_reg;
    assign vy_in_xcel = g_field[3].a_rd_reg;
    assign disp_x     = g_field[0].b_rd_reg;
    assign disp_y     = g_field[1].b_rd_reg;

`ifdef BOID_SCHED_PERF_EN
    logic [31:0] perf_cnt_reg;
    logic [31:0] perf_cnt_next;
    logic [31:0] frame_cycles_reg;

    // Latching the incremented value makes the done cycle itself part of the count.
    assign perf_cnt_next = (perf_cnt_reg == 32'hFFFF_FFFF) ? perf_cnt_reg : perf_cnt_reg + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt_reg     <= '0;
            frame_cycles_reg <= '0;
        end else begin
            if (start_accept) begin
                perf_cnt_reg <= '0;
            end else if (busy_reg) begin
                perf_cnt_reg <= perf_cnt_next;
            end
            if (done_reg) begin
                frame_cycles_reg <= perf_cnt_next;
            end
        end
    end

    assign frame_cycles = frame_cycles_reg;
`else
    assign frame_cycles = '0;
`endif

endmodule
